commit_unit: RTL and testbench

Writeback/commit stage sitting directly downstream of the execution ALUs (alu0, alu1, …). Each cycle it arbitrates round-robin among ALU result ports presenting `valid`, writes the selected result to the register file, turns taken-branch requests into a PC redirect with a fixed flush window, and converts ALU overflow errors into a halting exception. It drives each ALU's `clear` input, which retires the ALU's held result.

---
 rtl/core_config_pkg.sv | 21 ++
 rtl/commit_unit_rr_arbiter.sv | 31 +++
 rtl/commit_unit.sv | 190 +++++++++++++++++++
 tb/tb_commit_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/core_config_pkg.sv
// Core-wide configuration shared by the execution and commit stages.
// Holds datapath widths, commit-stage defaults and the commit FSM state type.
package core_config_pkg;

  localparam int XLEN                = 32;
  localparam int REG_ADDR_W          = 5;
  localparam int COMMIT_N_PORTS      = 4;
  localparam int COMMIT_FLUSH_CYCLES = 2;

  typedef enum logic [1:0] {
    CS_RUN   = 2'd0,
    CS_FLUSH = 2'd1,
    CS_HALT  = 2'd2
  } commit_state_t;

  // Index that follows idx in a ring of n entries.
  function automatic int unsigned ring_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/commit_unit_rr_arbiter.sv
// Combinational round-robin picker: returns the first requesting index at or
// after ptr, scanning upward and wrapping from N-1 back to 0.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant_idx,
  output logic             grant_vld
);

  int unsigned cand;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = 0;
    // Walk from the farthest offset to the nearest so the nearest match wins.
    for (int off = N - 1; off >= 0; off--) begin
      cand = (int'(ptr) + off) % N;
      if (req[cand]) begin
        grant_idx = IDX_W'(cand);
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/commit_unit.sv
// Writeback/commit stage: round-robin commit of ALU results, branch redirect
// with a fixed flush window, overflow-to-halt exception. Optional statistics
// counters are built when COMMIT_STATS_EN is defined.
module commit_unit
  import core_config_pkg::*;
#(
  parameter int N_PORTS      = COMMIT_N_PORTS,
  parameter int FLUSH_CYCLES = COMMIT_FLUSH_CYCLES
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [N_PORTS-1:0][XLEN-1:0]        alu_res,
  input  logic [N_PORTS-1:0][REG_ADDR_W-1:0]  alu_rd,
  input  logic [N_PORTS-1:0]                  alu_valid,
  input  logic [N_PORTS-1:0]                  alu_error,
  input  logic [N_PORTS-1:0]                  alu_req,
  output logic [N_PORTS-1:0]                  alu_clear,
  output logic                                rf_we,
  output logic [REG_ADDR_W-1:0]               rf_waddr,
  output logic [XLEN-1:0]                     rf_wdata,
  output logic                                pc_load,
  output logic [XLEN-1:0]                     pc_target,
  output logic                                flushing,
  output logic                                exc_valid,
  output logic [$clog2(N_PORTS)-1:0]          exc_port,
  output logic [XLEN-1:0]                     exc_value,
  input  logic                                exc_ack
`ifdef COMMIT_STATS_EN
  ,
  output logic [31:0]                         stat_commits,
  output logic [31:0]                         stat_flushes,
  output logic [15:0]                         stat_excs
`endif
);

  localparam int IDX_W = $clog2(N_PORTS);
  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  commit_state_t          state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]       flush_cnt_q, flush_cnt_d;

  logic [N_PORTS-1:0]     eligible;
  logic [IDX_W-1:0]       grant_idx;
  logic                   grant_vld;

  logic [N_PORTS-1:0]     alu_clear_d;
  logic                   rf_we_d;
  logic [REG_ADDR_W-1:0]  rf_waddr_d;
  logic [XLEN-1:0]        rf_wdata_d;
  logic                   pc_load_d;
  logic [XLEN-1:0]        pc_target_d;
  logic                   flushing_d;
  logic                   exc_valid_d;
  logic [IDX_W-1:0]       exc_port_d;
  logic [XLEN-1:0]        exc_value_d;
  logic                   commit_evt, flush_evt, exc_evt;

  // A port whose retire pulse is on the wire this cycle is still showing the
  // result we already took, so it must not be picked again.
  assign eligible = alu_valid & ~alu_clear;

  rr_arbiter #(
    .N     (N_PORTS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    flush_cnt_d = flush_cnt_q;
    alu_clear_d = '0;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr;
    rf_wdata_d  = rf_wdata;
    pc_load_d   = 1'b0;
    pc_target_d = pc_target;
    exc_valid_d = exc_valid;
    exc_port_d  = exc_port;
    exc_value_d = exc_value;
    commit_evt  = 1'b0;
    flush_evt   = 1'b0;
    exc_evt     = 1'b0;

    unique case (state_q)
      CS_RUN: begin
        if (grant_vld) begin
          alu_clear_d[grant_idx] = 1'b1;
          rr_ptr_d = IDX_W'(ring_next(int'(grant_idx), N_PORTS));
          if (alu_error[grant_idx]) begin
            exc_valid_d = 1'b1;
            exc_port_d  = grant_idx;
            exc_value_d = alu_res[grant_idx];
            exc_evt     = 1'b1;
            state_d     = CS_HALT;
          end else begin
            commit_evt = 1'b1;
            // Register x0 is hard-wired, so rd==0 retires without a write.
            rf_we_d    = (alu_rd[grant_idx] != '0);
            rf_waddr_d = alu_rd[grant_idx];
            rf_wdata_d = alu_res[grant_idx];
            if (alu_req[grant_idx]) begin
              pc_load_d   = 1'b1;
              pc_target_d = alu_res[grant_idx];
              flush_cnt_d = CNT_W'(FLUSH_CYCLES);
              flush_evt   = 1'b1;
              state_d     = CS_FLUSH;
            end
          end
        end
      end

      CS_FLUSH: begin
        alu_clear_d = eligible;
        flush_cnt_d = flush_cnt_q - 1'b1;
        if (flush_cnt_q <= CNT_W'(1)) state_d = CS_RUN;
      end

      CS_HALT: begin
        alu_clear_d = eligible;
        if (exc_ack) begin
          exc_valid_d = 1'b0;
          state_d     = CS_RUN;
        end
      end

      default: state_d = CS_RUN;
    endcase

    // Registered from the next state so the window lines up with FLUSH itself.
    flushing_d = (state_d == CS_FLUSH);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CS_RUN;
      rr_ptr_q    <= '0;
      flush_cnt_q <= '0;
      alu_clear   <= '0;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      pc_load     <= 1'b0;
      pc_target   <= '0;
      flushing    <= 1'b0;
      exc_valid   <= 1'b0;
      exc_port    <= '0;
      exc_value   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      flush_cnt_q <= flush_cnt_d;
      alu_clear   <= alu_clear_d;
      rf_we       <= rf_we_d;
      rf_waddr    <= rf_waddr_d;
      rf_wdata    <= rf_wdata_d;
      pc_load     <= pc_load_d;
      pc_target   <= pc_target_d;
      flushing    <= flushing_d;
      exc_valid   <= exc_valid_d;
      exc_port    <= exc_port_d;
      exc_value   <= exc_value_d;
    end
  end

`ifdef COMMIT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_commits <= '0;
      stat_flushes <= '0;
      stat_excs    <= '0;
    end else begin
      if (commit_evt) stat_commits <= stat_commits + 32'd1;
      if (flush_evt)  stat_flushes <= stat_flushes + 32'd1;
      if (exc_evt)    stat_excs    <= stat_excs + 16'd1;
    end
  end
`else
  logic unused_evt;
  assign unused_evt = commit_evt ^ flush_evt ^ exc_evt;
`endif

endmodule

// File: tb/tb_commit_unit.sv
// Directed bench for commit_unit: a small ALU model drops valid after its
// retire pulse, and expected register writes flow through a scoreboard queue.
module tb_commit_unit;
  import core_config_pkg::*;

  localparam int N = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wr_t;

  logic                           clk = 1'b0;
  logic                           rst_n;
  logic [N-1:0][XLEN-1:0]         alu_res;
  logic [N-1:0][REG_ADDR_W-1:0]   alu_rd;
  logic [N-1:0]                   alu_valid, alu_error, alu_req, alu_clear;
  logic                           rf_we, pc_load, flushing, exc_valid, exc_ack;
  logic [REG_ADDR_W-1:0]          rf_waddr;
  logic [XLEN-1:0]                rf_wdata, pc_target, exc_value;
  logic [$clog2(N)-1:0]           exc_port;

  wr_t sb[$];
  int  tests = 0;
  int  fails = 0;
  bit  hold  = 1'b0;

  commit_unit #(.N_PORTS(N), .FLUSH_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .alu_res   (alu_res),
    .alu_rd    (alu_rd),
    .alu_valid (alu_valid),
    .alu_error (alu_error),
    .alu_req   (alu_req),
    .alu_clear (alu_clear),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .flushing  (flushing),
    .exc_valid (exc_valid),
    .exc_port  (exc_port),
    .exc_value (exc_value),
    .exc_ack   (exc_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input int p, input logic [REG_ADDR_W-1:0] rd,
                         input logic [XLEN-1:0] res, input bit req, input bit err);
    alu_valid[p] = 1'b1;
    alu_rd[p]    = rd;
    alu_res[p]   = res;
    alu_req[p]   = req;
    alu_error[p] = err;
  endtask

  task automatic clear_inputs();
    alu_valid = '0;
    alu_error = '0;
    alu_req   = '0;
    alu_rd    = '0;
    alu_res   = '0;
  endtask

  // One clock: the ALU model retires ports whose clear was high across the
  // edge, then any register write is matched against the scoreboard.
  task automatic step();
    logic [N-1:0] clr;
    wr_t          e;
    clr = alu_clear;
    @(posedge clk);
    #1;
    if (!hold) begin
      for (int i = 0; i < N; i++) begin
        if (clr[i]) begin
          alu_valid[i] = 1'b0;
          alu_req[i]   = 1'b0;
          alu_error[i] = 1'b0;
        end
      end
    end
    if (rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("rf_write_unexpected", {59'd0, rf_waddr}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("rf_waddr", {59'd0, rf_waddr}, {59'd0, e.addr});
        check("rf_wdata", {32'd0, rf_wdata}, {32'd0, e.data});
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    exc_ack = 1'b0;
    clear_inputs();

    // Reset state
    step();
    step();
    check("rst_clear",     {60'd0, alu_clear}, 64'd0);
    check("rst_rf_we",     {63'd0, rf_we}, 64'd0);
    check("rst_rf_waddr",  {59'd0, rf_waddr}, 64'd0);
    check("rst_rf_wdata",  {32'd0, rf_wdata}, 64'd0);
    check("rst_pc_load",   {63'd0, pc_load}, 64'd0);
    check("rst_pc_target", {32'd0, pc_target}, 64'd0);
    check("rst_flushing",  {63'd0, flushing}, 64'd0);
    check("rst_exc_valid", {63'd0, exc_valid}, 64'd0);
    check("rst_exc_port",  {62'd0, exc_port}, 64'd0);
    check("rst_exc_value", {32'd0, exc_value}, 64'd0);
    rst_n = 1'b1;
    step();

    // Two ports pending from rr_ptr=0: port 0 then port 2
    present(0, 5'd5, 32'h11, 1'b0, 1'b0);
    present(2, 5'd6, 32'h22, 1'b0, 1'b0);
    sb.push_back('{addr: 5'd5, data: 32'h11});
    sb.push_back('{addr: 5'd6, data: 32'h22});
    step();
    check("two_t1_clear", {60'd0, alu_clear}, 64'b0001);
    check("two_t1_we",    {63'd0, rf_we}, 64'd1);
    step();
    check("two_t2_clear", {60'd0, alu_clear}, 64'b0100);
    check("two_t2_we",    {63'd0, rf_we}, 64'd1);
    step();
    check("two_t3_clear", {60'd0, alu_clear}, 64'd0);
    check("two_t3_we",    {63'd0, rf_we}, 64'd0);

    // rd=0 on port 3: retire pulse, no write; pointer wraps to 0
    present(3, 5'd0, 32'h55, 1'b0, 1'b0);
    step();
    check("rd0_clear", {60'd0, alu_clear}, 64'b1000);
    check("rd0_we",    {63'd0, rf_we}, 64'd0);
    step();
    check("rd0_idle_clear", {60'd0, alu_clear}, 64'd0);

    // All ports continuously valid for 8 cycles
    hold = 1'b1;
    for (int p = 0; p < N; p++) present(p, REG_ADDR_W'(p + 1), XLEN'(32'hA0 + p), 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) sb.push_back('{addr: REG_ADDR_W'(k % N + 1), data: XLEN'(32'hA0 + k % N)});
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("rr_order_%0d", k), {60'd0, alu_clear}, 64'(1 << (k % N)));
    end
    clear_inputs();
    hold = 1'b0;
    step();
    check("rr_idle_clear", {60'd0, alu_clear}, 64'd0);
    check("rr_idle_we",    {63'd0, rf_we}, 64'd0);

    // Taken branch on port 1 with link write, port 3 flushed without a write
    present(1, 5'd1, 32'h100, 1'b1, 1'b0);
    present(3, 5'd7, 32'h77, 1'b0, 1'b0);
    sb.push_back('{addr: 5'd1, data: 32'h100});
    step();
    check("br_pc_load",   {63'd0, pc_load}, 64'd1);
    check("br_pc_target", {32'd0, pc_target}, 64'h100);
    check("br_flush_t1",  {63'd0, flushing}, 64'd1);
    check("br_clear_t1",  {60'd0, alu_clear}, 64'b0010);
    check("br_we_t1",     {63'd0, rf_we}, 64'd1);
    step();
    check("br_flush_t2",  {63'd0, flushing}, 64'd1);
    check("br_clear_t2",  {60'd0, alu_clear}, 64'b1000);
    check("br_pc_pulse",  {63'd0, pc_load}, 64'd0);
    check("br_we_t2",     {63'd0, rf_we}, 64'd0);
    step();
    check("br_flush_t3",  {63'd0, flushing}, 64'd0);
    check("br_clear_t3",  {60'd0, alu_clear}, 64'd0);
    check("br_we_t3",     {63'd0, rf_we}, 64'd0);

    // Overflow on port 2 halts; later results are cleared without writes
    present(2, 5'd9, 32'hFFFF_FFF0, 1'b0, 1'b1);
    step();
    check("exc_valid",  {63'd0, exc_valid}, 64'd1);
    check("exc_port",   {62'd0, exc_port}, 64'd2);
    check("exc_value",  {32'd0, exc_value}, 64'hFFFF_FFF0);
    check("exc_we",     {63'd0, rf_we}, 64'd0);
    check("exc_clear",  {60'd0, alu_clear}, 64'b0100);
    present(0, 5'd3, 32'h33, 1'b0, 1'b0);
    present(1, 5'd4, 32'h44, 1'b0, 1'b0);
    step();
    check("halt_clear",     {60'd0, alu_clear}, 64'b0011);
    check("halt_we",        {63'd0, rf_we}, 64'd0);
    check("halt_pc",        {63'd0, pc_load}, 64'd0);
    check("halt_exc_value", {32'd0, exc_value}, 64'hFFFF_FFF0);
    step();
    check("halt_hold_valid", {63'd0, exc_valid}, 64'd1);
    check("halt_hold_port",  {62'd0, exc_port}, 64'd2);
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    check("ack_exc_valid", {63'd0, exc_valid}, 64'd0);
    present(0, 5'd3, 32'h33, 1'b0, 1'b0);
    sb.push_back('{addr: 5'd3, data: 32'h33});
    step();
    check("resume_clear", {60'd0, alu_clear}, 64'b0001);
    check("resume_we",    {63'd0, rf_we}, 64'd1);
    step();

    // exc_ack outside HALT has no effect
    exc_ack = 1'b1;
    step();
    exc_ack = 1'b0;
    check("stray_ack_exc", {63'd0, exc_valid}, 64'd0);
    check("stray_ack_clr", {60'd0, alu_clear}, 64'd0);

    // Reset while halted; pointer must restart at 0
    present(1, 5'd2, 32'hDEAD_BEEF, 1'b0, 1'b1);
    step();
    check("pre_rst_exc", {63'd0, exc_valid}, 64'd1);
    check("pre_rst_port", {62'd0, exc_port}, 64'd1);
    present(2, 5'd8, 32'h88, 1'b0, 1'b0);
    rst_n = 1'b0;
    step();
    check("hrst_clear",     {60'd0, alu_clear}, 64'd0);
    check("hrst_exc_valid", {63'd0, exc_valid}, 64'd0);
    check("hrst_exc_port",  {62'd0, exc_port}, 64'd0);
    check("hrst_exc_value", {32'd0, exc_value}, 64'd0);
    check("hrst_flushing",  {63'd0, flushing}, 64'd0);
    check("hrst_we",        {63'd0, rf_we}, 64'd0);
    check("hrst_pc_target", {32'd0, pc_target}, 64'd0);
    clear_inputs();
    rst_n = 1'b1;
    step();
    present(1, 5'd10, 32'hA1, 1'b0, 1'b0);
    present(3, 5'd11, 32'hA3, 1'b0, 1'b0);
    sb.push_back('{addr: 5'd10, data: 32'hA1});
    sb.push_back('{addr: 5'd11, data: 32'hA3});
    step();
    check("post_rst_first",  {60'd0, alu_clear}, 64'b0010);
    step();
    check("post_rst_second", {60'd0, alu_clear}, 64'b1000);
    step();

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
